// File: rtl/fv_core_if_instr_seq_constraint.sv
`timescale 1ns/1ps
// Tracks an accepted RVC stream and flags budget, control-flow gap and program-length rule breaks.
// instr_ok is combinational (0 cycles); in_ready is high only in RUN and there is no other backpressure.
module fv_core_if_instr_seq_constraint #(
  parameter int NUM_CAT   = 8,
  parameter int CNT_W     = 4,
  parameter int MAX_INSTR = 16,
  parameter int CF_GAP    = 2,
  parameter int DRAIN_CYC = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic [NUM_CAT-1:0]           cat_vec,
  input  logic [NUM_CAT*CNT_W-1:0]     cat_budget,
  input  logic [NUM_CAT-1:0]           cf_mask,
  input  logic [NUM_CAT-1:0]           term_mask,
  output logic                         in_ready,
  output logic                         instr_ok,
  output logic [NUM_CAT*CNT_W-1:0]     cat_count,
  output logic [$clog2(MAX_INSTR+1)-1:0] total_count,
  output logic [1:0]                   state,
  output logic                         done,
  output logic                         violation
);

  localparam int TW  = $clog2(MAX_INSTR+1);
  localparam int GW  = $clog2(CF_GAP+2);
  localparam int DRW = $clog2(DRAIN_CYC+1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                         r_state;
  state_t                         w_next_state;
  logic [NUM_CAT-1:0][CNT_W-1:0]  r_cat_cnt;
  logic [TW-1:0]                  r_total;
  logic [GW-1:0]                  r_gap;
  logic [DRW-1:0]                 r_drain;
  logic                           r_violation;

  logic [CNT_W-1:0]               w_sel_cnt;
  logic [CNT_W-1:0]               w_sel_bud;
  logic                           w_sel_cf;
  logic                           w_sel_term;
  logic                           w_onehot;
  logic                           w_run;
  logic                           w_accept;
  logic                           w_ok;

  assign w_run    = (r_state == S_RUN);
  assign w_accept = in_valid && w_run;
  assign w_onehot = (cat_vec != '0) && ((cat_vec & (cat_vec - 1'b1)) == '0);

  // cat_vec is one-hot whenever the result matters, so an AND-OR mux selects the category.
  always_comb begin
    w_sel_cnt  = '0;
    w_sel_bud  = '0;
    w_sel_cf   = 1'b0;
    w_sel_term = 1'b0;
    for (int c = 0; c < NUM_CAT; c++) begin
      if (cat_vec[c]) begin
        w_sel_cnt  = w_sel_cnt | r_cat_cnt[c];
        w_sel_bud  = w_sel_bud | cat_budget[c*CNT_W +: CNT_W];
        w_sel_cf   = w_sel_cf | cf_mask[c];
        w_sel_term = w_sel_term | term_mask[c];
      end
    end
  end

  assign w_ok = w_run && w_onehot
             && (w_sel_cnt < w_sel_bud)
             && (!w_sel_cf || (r_gap == '0))
             && (r_total < TW'(MAX_INSTR))
             && ((r_total != TW'(MAX_INSTR-1)) || w_sel_term);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN;
      S_RUN:   if (w_accept && w_ok && w_sel_term) w_next_state = S_DRAIN;
      S_DRAIN: if (r_drain == '0) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_DONE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cat_cnt   <= '0;
      r_total     <= '0;
      r_gap       <= '0;
      r_drain     <= '0;
      r_violation <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_ok) begin
          for (int c = 0; c < NUM_CAT; c++)
            if (cat_vec[c]) r_cat_cnt[c] <= r_cat_cnt[c] + 1'b1;
          r_total <= r_total + 1'b1;
          if (w_sel_cf)             r_gap <= GW'(CF_GAP);
          else if (r_gap != '0)     r_gap <= r_gap - 1'b1;
          if (w_sel_term)           r_drain <= DRW'(DRAIN_CYC-1);
        end else begin
          r_violation <= 1'b1;
        end
      end
      if ((r_state == S_DRAIN) && (r_drain != '0)) r_drain <= r_drain - 1'b1;
    end
  end

  assign in_ready    = w_run;
  assign instr_ok    = w_ok;
  assign cat_count   = r_cat_cnt;
  assign total_count = r_total;
  assign state       = r_state;
  assign done        = (r_state == S_DONE);
  assign violation   = r_violation;

  a_ok_onehot: assert property (@(posedge clk) disable iff (!reset_n) instr_ok |-> $onehot(cat_vec));
  a_total_max: assert property (@(posedge clk) disable iff (!reset_n) r_total <= TW'(MAX_INSTR));

endmodule

// File: tb/tb_fv_core_if_instr_seq_constraint.sv
`timescale 1ns/1ps
// Directed bench for the instruction sequence constraint block.
module tb_fv_core_if_instr_seq_constraint;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  cat_vec;
  logic [31:0] cat_budget;
  logic [7:0]  cf_mask;
  logic [7:0]  term_mask;
  logic        in_ready;
  logic        instr_ok;
  logic [31:0] cat_count;
  logic [4:0]  total_count;
  logic [1:0]  state;
  logic        done;
  logic        violation;

  int n_checks = 0;
  int n_errors = 0;

  fv_core_if_instr_seq_constraint dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .cat_vec(cat_vec), .cat_budget(cat_budget), .cf_mask(cf_mask),
    .term_mask(term_mask), .in_ready(in_ready), .instr_ok(instr_ok),
    .cat_count(cat_count), .total_count(total_count), .state(state),
    .done(done), .violation(violation)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt(input int c);
    return {28'd0, cat_count[c*4 +: 4]};
  endfunction

  // Present one instruction, check instr_ok, then clock it in.
  task automatic present(input logic [7:0] cv, input logic exp_ok, input string tag);
    cat_vec  = cv;
    in_valid = 1'b1;
    #1;
    check(tag, {31'd0, instr_ok}, {31'd0, exp_ok});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic probe(input logic [7:0] cv, input logic exp_ok, input string tag);
    cat_vec  = cv;
    in_valid = 1'b0;
    #1;
    check(tag, {31'd0, instr_ok}, {31'd0, exp_ok});
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    in_valid   = 1'b0;
    cat_vec    = '0;
    // budgets: cat7=1, cat4=15, cat1=15, cat0=3, others disabled
    cat_budget = {4'd1, 4'd0, 4'd0, 4'd15, 4'd0, 4'd0, 4'd15, 4'd3};
    cf_mask    = 8'h10;
    term_mask  = 8'h80;
    tick(); tick();
    check("rst_state", {30'd0, state}, 0);
    check("rst_total", {27'd0, total_count}, 0);
    check("rst_counts", cat_count, 0);
    check("rst_viol", {31'd0, violation}, 0);
    check("rst_ready", {31'd0, in_ready}, 0);
    check("rst_done", {31'd0, done}, 0);
    reset_n = 1'b1;

    // in_valid while IDLE is ignored
    cat_vec = 8'h01; in_valid = 1'b1;
    tick();
    check("idle_state", {30'd0, state}, 0);
    check("idle_ready", {31'd0, in_ready}, 0);
    check("idle_cnt0", cnt(0), 0);
    // start together with in_valid: only the transition
    start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    check("start_state", {30'd0, state}, 1);
    check("start_total", {27'd0, total_count}, 0);
    check("start_ready", {31'd0, in_ready}, 1);

    // budget on cat0 = 3
    for (int i = 1; i <= 3; i++) begin
      present(8'h01, 1'b1, "alu_ok");
      check("alu_cnt", cnt(0), i);
    end
    present(8'h01, 1'b0, "alu_over");
    check("over_viol", {31'd0, violation}, 1);
    check("over_cnt0", cnt(0), 3);
    check("over_total", {27'd0, total_count}, 3);
    check("over_state", {30'd0, state}, 1);

    // malformed category vectors and a disabled category
    probe(8'h00, 1'b0, "cv_zero");
    probe(8'h03, 1'b0, "cv_two");
    cat_budget[28 +: 4] = 4'd0;
    probe(8'h80, 1'b0, "cv_nobud");
    cat_budget[28 +: 4] = 4'd1;
    probe(8'h80, 1'b1, "cv_bud1");

    // control-flow gap
    present(8'h10, 1'b1, "cj1");
    probe(8'h10, 1'b0, "cj_back");
    present(8'h02, 1'b1, "gap_alu1");
    probe(8'h10, 1'b0, "cj_gap1");
    present(8'h02, 1'b1, "gap_alu2");
    present(8'h10, 1'b1, "cj_gap0");
    check("cf_cnt4", cnt(4), 2);
    check("cf_total", {27'd0, total_count}, 7);

    // fill the program up to MAX_INSTR-1
    for (int i = 0; i < 8; i++) present(8'h02, 1'b1, "fill_alu");
    check("fill_total", {27'd0, total_count}, 15);
    check("fill_cnt1", cnt(1), 10);
    probe(8'h02, 1'b0, "last_nonterm");
    present(8'h80, 1'b1, "ebreak");
    check("eb_total", {27'd0, total_count}, 16);
    check("eb_cnt7", cnt(7), 1);

    // DRAIN lasts 4 cycles, then DONE; inputs are ignored
    in_valid = 1'b1; cat_vec = 8'h02;
    for (int i = 0; i < 4; i++) begin
      check("drain_state", {30'd0, state}, 2);
      check("drain_ready", {31'd0, in_ready}, 0);
      tick();
    end
    check("done_state", {30'd0, state}, 3);
    check("done_flag", {31'd0, done}, 1);
    check("done_ready", {31'd0, in_ready}, 0);
    tick();
    check("done_total", {27'd0, total_count}, 16);
    check("done_cnt1", cnt(1), 10);
    check("done_viol", {31'd0, violation}, 1);
    in_valid = 1'b0;

    // reset in the middle of DRAIN
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    present(8'h00, 1'b0, "r2_bad");
    check("r2_viol", {31'd0, violation}, 1);
    present(8'h80, 1'b1, "r2_eb");
    tick();
    check("r2_drain", {30'd0, state}, 2);
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    check("mid_rst_state", {30'd0, state}, 0);
    check("mid_rst_counts", cat_count, 0);
    check("mid_rst_total", {27'd0, total_count}, 0);
    check("mid_rst_viol", {31'd0, violation}, 0);
    start = 1'b1; tick(); start = 1'b0;
    present(8'h01, 1'b1, "fresh_alu");
    check("fresh_cnt0", cnt(0), 1);
    check("fresh_state", {30'd0, state}, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fv_core_if_instr_seq_constraint.md
Name: fv_core_if_instr_seq_constraint

Overview:
- Sequential successor to the per-instruction RVC category classifier.
- Consumes the classifier's per-cycle category vector and tracks the accepted instruction stream over time.
- Produces a legality signal for the formal environment to assume. It enforces:
  - per-category budgets,
  - a minimum gap between control-flow instructions,
  - a bounded program length that must end with a terminating instruction (e.g. C.EBREAK), followed by a drain period.
- Category count and stream rules are parametrised.

Parameters:
- NUM_CAT, 8, number of instruction categories (one bit each in cat_vec).
- CNT_W, 4, width of each per-category counter and budget field.
- MAX_INSTR, 16, maximum accepted instructions per program, terminator included; must be >= 1.
- CF_GAP, 2, number of accepted non-control-flow instructions required between two control-flow instructions.
- DRAIN_CYC, 4, cycles spent in DRAIN after the terminator is accepted; must be >= 1.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  pulse; moves IDLE to RUN.
- in_valid  in  1  an instruction is presented this cycle.
- cat_vec  in  NUM_CAT  category of the presented instruction; legal only if one-hot.
- cat_budget  in  NUM_CAT*CNT_W  static per-category limit; field c is bits [c*CNT_W +: CNT_W]; 0 disables the category.
- cf_mask  in  NUM_CAT  categories treated as control flow (jumps/branches).
- term_mask  in  NUM_CAT  terminating categories.
- in_ready  out  1  block accepts instructions (state==RUN).
- instr_ok  out  1  combinational: the presented instruction is legal in the current state.
- cat_count  out  NUM_CAT*CNT_W  accepted count per category.
- total_count  out  $clog2(MAX_INSTR+1)  accepted instructions in this program.
- state  out  2  IDLE=0, RUN=1, DRAIN=2, DONE=3.
- done  out  1  state==DONE.
- violation  out  1  sticky: an illegal instruction was accepted.

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low; it takes priority over all other events, including mid-RUN and mid-DRAIN.
- Reset values: state=IDLE, all cat_count=0, total_count=0, gap_cnt=0, drain_cnt=0, violation=0, in_ready=0, done=0.
- Acceptance: accept = in_valid && in_ready. There is no backpressure beyond in_ready. in_valid outside RUN is ignored and changes no state.
- instr_ok is the AND of all of:
  - state==RUN.
  - popcount(cat_vec)==1.
  - Selected category c satisfies cat_count[c] < cat_budget[c] (unsigned).
  - If cf_mask[c]: gap_cnt==0.
  - total_count < MAX_INSTR.
  - If total_count==MAX_INSTR-1: term_mask[c]==1 (the last slot must be the terminator).
- instr_ok is a pure function of the current state and inputs; there is no registered latency.
- Accepted and legal (accept && instr_ok), applied on the next clock edge:
  - cat_count[c]++ and total_count++.
  - If cf_mask[c]: gap_cnt <= CF_GAP.
  - Otherwise, if gap_cnt>0: gap_cnt--.
  - If term_mask[c]: state <= DRAIN and drain_cnt <= DRAIN_CYC-1.
- Accepted and illegal: violation <= 1 (stays set until reset). Counters and state are unchanged, and the block stays in RUN.
- A category set in both cf_mask and term_mask applies both rules.
- Counters never wrap: the budget check prevents cat_count overflow, and the MAX_INSTR check prevents total_count overflow.
- FSM:
  - IDLE -> RUN on start.
  - RUN -> DRAIN on an accepted legal terminator.
  - DRAIN: drain_cnt decrements each cycle; when it reaches 0, the next edge moves to DONE. DRAIN therefore lasts exactly DRAIN_CYC cycles.
  - DONE holds until reset.
  - start is ignored outside IDLE.
  - start and in_valid in the same IDLE cycle: only the transition to RUN happens; nothing is accepted that cycle.
- Hold during DRAIN/DONE: in_ready=0 and all counters hold their values.
- Checks: internal assertions check that instr_ok implies cat_vec is one-hot, and that total_count never exceeds MAX_INSTR.

Test Plan:
- Reset, start, then ALU-I (cat 0, budget 3) presented 4 times -> first 3 cycles have instr_ok=1, cat_count[0] goes 1,2,3; 4th has instr_ok=0, and accepting it sets violation=1 with counts unchanged.
- CF category (cat 4, CF_GAP=2): CJ, then CJ -> second has instr_ok=0; CJ, ALU, ALU, CJ -> second CJ has instr_ok=1 (gap_cnt goes 2,1,0).
- MAX_INSTR=16: 15 legal ALU instructions accepted, then ALU presented -> instr_ok=0; then EBREAK (term cat 7) -> instr_ok=1, total_count=16, state=DRAIN for 4 cycles, then DONE with done=1 and in_ready=0.
- cat_vec=0 or two bits set (e.g. 8'b0000_0011) in RUN -> instr_ok=0; cat_vec=8'b1000_0000 with cat_budget[7]=0 -> instr_ok=0.
- in_valid=1 in IDLE and in DONE -> in_ready=0 and no counter change; start and in_valid together in IDLE -> state=RUN next cycle, total_count=0.
- Assert reset_n=0 during DRAIN with drain_cnt=2 -> next edge gives state=IDLE, all counts 0, violation 0; a fresh start runs normally.
